pll_phase_ctrl: RTL and testbench

Sequencer for the ECP5 EHXPLLL that generates the 125/25/52.08 MHz clocks. It owns the PLL reset, filters the PLL `locked` indication into a clean `pll_ready`, and executes dynamic phase-shift requests on the PLL's PHASESEL/PHASEDIR/PHASESTEP pins. Runs in the 25 MHz reference-clock domain, ahead of every consumer of the PLL outputs.

---
 rtl/pll_ctrl_pkg.sv | 37 +++
 rtl/pll_lock_filter.sv | 43 ++++
 rtl/pll_phase_ctrl.sv | 122 ++++++++++++
 tb/tb_pll_phase_ctrl.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/pll_ctrl_pkg.sv
// Shared types and constants for the ECP5 EHXPLLL sequencer.
//   state_t     : sequencer states
//   IDLE_*      : PHASESEL/PHASEDIR/PHASESTEP values held whenever no shift runs
//   SEL_*       : PHASESEL encodings for the four PLL outputs
//   phase_req_t : latched phase-shift request
package pll_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_PLL_RST,
    ST_WAIT_LOCK,
    ST_IDLE,
    ST_SETUP,
    ST_STEP_LO,
    ST_STEP_HI,
    ST_FINISH
  } state_t;

  localparam logic [1:0] SEL_CLKOP  = 2'd0;
  localparam logic [1:0] SEL_CLKOS  = 2'd1;
  localparam logic [1:0] SEL_CLKOS2 = 2'd2;
  localparam logic [1:0] SEL_CLKOS3 = 2'd3;

  localparam logic [1:0] IDLE_SEL  = SEL_CLKOP;
  localparam logic       IDLE_DIR  = 1'b1;
  localparam logic       IDLE_STEP = 1'b1;

  typedef struct packed {
    logic [1:0] sel;
    logic       dir;
    logic [7:0] steps;
  } phase_req_t;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/pll_lock_filter.sv
// Lock qualifier: 2-flop synchronizer on the raw PLL LOCK followed by a
// saturating run-length counter.
//   clk, reset_n : reference clock, async active-low reset
//   pll_locked   : raw LOCK, asynchronous to clk
//   pll_ready    : high while the counter sits at LOCK_FILTER
//   ready_nxt    : value pll_ready takes at the next edge; lets the
//                  sequencer register req_ready in step with pll_ready
module pll_lock_filter #(
  parameter int LOCK_FILTER = 1024
) (
  input  logic clk,
  input  logic reset_n,
  input  logic pll_locked,
  output logic pll_ready,
  output logic ready_nxt
);

  localparam int CW = $clog2(LOCK_FILTER + 1);

  logic [1:0]    sync;
  logic [CW-1:0] cnt, cnt_nxt;

  // Any synchronized low sample restarts the run.
  always_comb begin
    cnt_nxt = '0;
    if (sync[1]) cnt_nxt = (cnt == CW'(LOCK_FILTER)) ? cnt : cnt + 1'b1;
  end

  assign ready_nxt = (cnt_nxt == CW'(LOCK_FILTER));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync      <= '0;
      cnt       <= '0;
      pll_ready <= 1'b0;
    end else begin
      sync      <= {sync[0], pll_locked};
      cnt       <= cnt_nxt;
      pll_ready <= ready_nxt;
    end
  end

endmodule

// File: rtl/pll_phase_ctrl.sv
// Sequencer for the ECP5 EHXPLLL: owns PLL reset, qualifies lock, and runs
// dynamic phase shifts on PHASESEL/PHASEDIR/PHASESTEP.
//   clk, reset_n               : 25 MHz reference clock, async active-low reset
//   pll_locked                 : raw PLL LOCK
//   req_valid/req_ready        : phase request handshake
//   req_sel/req_dir/req_steps  : output select, direction, pulse count
//   pll_rst                    : PLL RST
//   phasesel/phasedir/phasestep: PLL dynamic phase pins
//   pll_ready                  : filtered lock
//   done / aborted             : one-cycle completion / lock-loss pulses
// All outputs are registered from the next-state decode, so every pin
// changes on the same edge the state does.
module pll_phase_ctrl
  import pll_ctrl_pkg::*;
#(
  parameter int RST_CYCLES   = 16,
  parameter int LOCK_FILTER  = 1024,
  parameter int LOCK_TIMEOUT = 65536,
  parameter int SETUP_CYCLES = 2,
  parameter int STEP_PULSE   = 4
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       pll_locked,
  input  logic       req_valid,
  output logic       req_ready,
  input  logic [1:0] req_sel,
  input  logic       req_dir,
  input  logic [7:0] req_steps,
  output logic       pll_rst,
  output logic [1:0] phasesel,
  output logic       phasedir,
  output logic       phasestep,
  output logic       pll_ready,
  output logic       done,
  output logic       aborted
);

  localparam int CMAX = max_int(max_int(RST_CYCLES, LOCK_TIMEOUT),
                                max_int(SETUP_CYCLES, STEP_PULSE));
  localparam int CW   = $clog2(CMAX + 1);

  state_t        state, nxt;
  phase_req_t    req_q, req_nxt;
  logic [CW-1:0] cnt, cnt_nxt;
  logic          ready_nxt, abort, active;

  pll_lock_filter #(.LOCK_FILTER(LOCK_FILTER)) u_filter (
    .clk        (clk),
    .reset_n    (reset_n),
    .pll_locked (pll_locked),
    .pll_ready  (pll_ready),
    .ready_nxt  (ready_nxt)
  );

  always_comb begin
    nxt     = state;
    req_nxt = req_q;
    abort   = 1'b0;
    unique case (state)
      ST_PLL_RST:   if (cnt == CW'(RST_CYCLES - 1)) nxt = ST_WAIT_LOCK;
      // Look ahead one edge so IDLE, pll_ready and req_ready appear together.
      ST_WAIT_LOCK: if (ready_nxt) nxt = ST_IDLE;
                    else if (cnt == CW'(LOCK_TIMEOUT - 1)) nxt = ST_PLL_RST;
      ST_IDLE: begin
        if (!pll_ready) nxt = ST_WAIT_LOCK;
        else if (req_valid && req_ready) begin
          nxt     = ST_SETUP;
          req_nxt = '{sel: req_sel, dir: req_dir, steps: req_steps};
        end
      end
      ST_SETUP:     if (cnt == CW'(SETUP_CYCLES - 1))
                      nxt = (req_q.steps == 8'd0) ? ST_FINISH : ST_STEP_LO;
      ST_STEP_LO:   if (cnt == CW'(STEP_PULSE - 1)) nxt = ST_STEP_HI;
      ST_STEP_HI: begin
        if (cnt == CW'(STEP_PULSE - 1)) begin
          req_nxt.steps = req_q.steps - 8'd1;
          nxt = (req_q.steps == 8'd1) ? ST_FINISH : ST_STEP_LO;
        end
      end
      ST_FINISH:    nxt = ST_IDLE;
      default:      nxt = ST_PLL_RST;
    endcase
    // Lock loss mid-shift wins over any step bookkeeping above.
    if ((state inside {ST_SETUP, ST_STEP_LO, ST_STEP_HI}) && !pll_ready) begin
      nxt           = ST_WAIT_LOCK;
      abort         = 1'b1;
      req_nxt.steps = 8'd0;
    end
  end

  // cnt measures time spent in the current state; IDLE holds it at zero.
  assign cnt_nxt = ((nxt != state) || (state == ST_IDLE)) ? '0 : cnt + 1'b1;
  assign active  = nxt inside {ST_SETUP, ST_STEP_LO, ST_STEP_HI};

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= ST_PLL_RST;
      cnt       <= '0;
      req_q     <= '{sel: IDLE_SEL, dir: IDLE_DIR, steps: 8'd0};
      pll_rst   <= 1'b1;
      phasesel  <= IDLE_SEL;
      phasedir  <= IDLE_DIR;
      phasestep <= IDLE_STEP;
      req_ready <= 1'b0;
      done      <= 1'b0;
      aborted   <= 1'b0;
    end else begin
      state     <= nxt;
      cnt       <= cnt_nxt;
      req_q     <= req_nxt;
      pll_rst   <= (nxt == ST_PLL_RST);
      phasesel  <= active ? req_nxt.sel : IDLE_SEL;
      phasedir  <= active ? req_nxt.dir : IDLE_DIR;
      phasestep <= (nxt == ST_STEP_LO) ? ~IDLE_STEP : IDLE_STEP;
      req_ready <= (nxt == ST_IDLE) && ready_nxt;
      done      <= (nxt == ST_FINISH);
      aborted   <= abort;
    end
  end

endmodule

// File: tb/tb_pll_phase_ctrl.sv
// Directed bench for pll_phase_ctrl with RST_CYCLES=4, LOCK_FILTER=8,
// LOCK_TIMEOUT=64, SETUP_CYCLES=2, STEP_PULSE=2.
// Outputs are sampled #1 after a rising edge. A sample taken after edge N+k
// is the value the PLL sees at edge N+k+1, so "done at N+15" is offset 14.
module tb_pll_phase_ctrl;

  logic       clk = 1'b0;
  logic       reset_n, pll_locked, req_valid, req_dir;
  logic [1:0] req_sel;
  logic [7:0] req_steps;
  logic       req_ready, pll_rst, phasedir, phasestep, pll_ready, done, aborted;
  logic [1:0] phasesel;

  int checks = 0;
  int passed = 0;

  pll_phase_ctrl #(
    .RST_CYCLES(4), .LOCK_FILTER(8), .LOCK_TIMEOUT(64),
    .SETUP_CYCLES(2), .STEP_PULSE(2)
  ) dut (
    .clk(clk), .reset_n(reset_n), .pll_locked(pll_locked),
    .req_valid(req_valid), .req_ready(req_ready), .req_sel(req_sel),
    .req_dir(req_dir), .req_steps(req_steps), .pll_rst(pll_rst),
    .phasesel(phasesel), .phasedir(phasedir), .phasestep(phasestep),
    .pll_ready(pll_ready), .done(done), .aborted(aborted)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset_n = 1'b0; pll_locked = 1'b0; req_valid = 1'b0;
    req_sel = 2'd0; req_dir = 1'b1; req_steps = 8'd0;
    tick(); tick();
    checks++; if (pll_rst   !== 1'b1)  $display("FAIL reset_pll_rst: got %b want 1", pll_rst);   else passed++;
    checks++; if (phasesel  !== 2'd0)  $display("FAIL reset_phasesel: got %0d want 0", phasesel); else passed++;
    checks++; if (phasedir  !== 1'b1)  $display("FAIL reset_phasedir: got %b want 1", phasedir); else passed++;
    checks++; if (phasestep !== 1'b1)  $display("FAIL reset_phasestep: got %b want 1", phasestep); else passed++;
    checks++; if (pll_ready !== 1'b0)  $display("FAIL reset_pll_ready: got %b want 0", pll_ready); else passed++;
    checks++; if (req_ready !== 1'b0)  $display("FAIL reset_req_ready: got %b want 0", req_ready); else passed++;
    checks++; if (done      !== 1'b0)  $display("FAIL reset_done: got %b want 0", done);         else passed++;
    checks++; if (aborted   !== 1'b0)  $display("FAIL reset_aborted: got %b want 0", aborted);   else passed++;
  endtask

  task automatic test_startup();
    int hi = 0;
    reset_n = 1'b1;
    if (pll_rst === 1'b1) hi++;
    for (int k = 1; k <= 10; k++) begin
      tick();
      if (pll_rst === 1'b1) hi++;
    end
    checks++; if (hi != 4) $display("FAIL startup_rst_width: got %0d want 4", hi); else passed++;
    pll_locked = 1'b1;
    repeat (9) tick();
    checks++; if ({pll_ready, req_ready} !== 2'b00)
      $display("FAIL startup_early_ready: got %b want 00", {pll_ready, req_ready}); else passed++;
    tick();
    checks++; if ({pll_ready, req_ready} !== 2'b11)
      $display("FAIL startup_ready: got %b want 11", {pll_ready, req_ready}); else passed++;
  endtask

  task automatic test_step();
    logic [16:0] lo = '0, act = '0, idl = '0, dn = '0, rdy = '0;
    logic        ab = 1'b0;
    req_sel = 2'd2; req_dir = 1'b0; req_steps = 8'd3; req_valid = 1'b1;
    tick();
    req_valid = 1'b0;
    for (int k = 0; k < 17; k++) begin
      lo[k]  = (phasestep === 1'b0);
      act[k] = (phasesel === 2'd2) && (phasedir === 1'b0);
      idl[k] = (phasesel === 2'd0) && (phasedir === 1'b1);
      dn[k]  = (done === 1'b1);
      rdy[k] = (req_ready === 1'b1);
      ab     = ab | (aborted === 1'b1);
      if (k < 16) tick();
    end
    // lows at offsets 2,3 6,7 10,11; sel/dir live 0..13; done 14; ready 15..
    checks++; if (lo  !== 17'h00CCC) $display("FAIL step_pulses: got %h want 00ccc", lo);  else passed++;
    checks++; if (act !== 17'h03FFF) $display("FAIL step_seldir: got %h want 03fff", act); else passed++;
    checks++; if (idl !== 17'h1C000) $display("FAIL step_restore: got %h want 1c000", idl); else passed++;
    checks++; if (dn  !== 17'h04000) $display("FAIL step_done: got %h want 04000", dn);    else passed++;
    checks++; if (rdy !== 17'h18000) $display("FAIL step_req_ready: got %h want 18000", rdy); else passed++;
    checks++; if (ab  !== 1'b0)      $display("FAIL step_aborted: got %b want 0", ab);     else passed++;
  endtask

  task automatic test_zero_steps();
    logic [5:0] lo = '0, act = '0, dn = '0, rdy = '0;
    req_sel = 2'd1; req_dir = 1'b0; req_steps = 8'd0; req_valid = 1'b1;
    tick();
    req_valid = 1'b0;
    for (int k = 0; k < 6; k++) begin
      lo[k]  = (phasestep === 1'b0);
      act[k] = (phasesel === 2'd1) && (phasedir === 1'b0);
      dn[k]  = (done === 1'b1);
      rdy[k] = (req_ready === 1'b1);
      if (k < 5) tick();
    end
    checks++; if (lo  !== 6'b000000) $display("FAIL zero_pulses: got %b want 000000", lo);  else passed++;
    checks++; if (act !== 6'b000011) $display("FAIL zero_seldir: got %b want 000011", act); else passed++;
    checks++; if (dn  !== 6'b000100) $display("FAIL zero_done: got %b want 000100", dn);    else passed++;
    checks++; if (rdy !== 6'b111000) $display("FAIL zero_req_ready: got %b want 111000", rdy); else passed++;
  endtask

  task automatic test_abort();
    logic [20:0] lo = '0, act = '0, rd = '0, ab = '0, dn = '0, rq = '0;
    req_sel = 2'd3; req_dir = 1'b1; req_steps = 8'd5; req_valid = 1'b1;
    tick();
    req_valid = 1'b0;
    for (int k = 0; k < 21; k++) begin
      lo[k]  = (phasestep === 1'b0);
      act[k] = (phasesel === 2'd3);
      rd[k]  = (pll_ready === 1'b1);
      ab[k]  = (aborted === 1'b1);
      dn[k]  = (done === 1'b1);
      rq[k]  = (req_ready === 1'b1);
      if (k == 6) pll_locked = 1'b0;   // second pulse is low at offsets 6,7
      if (k < 20) tick();
    end
    checks++; if (rd  !== 21'h0001FF) $display("FAIL abort_ready_fall: got %h want 0001ff", rd); else passed++;
    checks++; if (lo  !== 21'h0000CC) $display("FAIL abort_pulses: got %h want 0000cc", lo);    else passed++;
    checks++; if (ab  !== 21'h000400) $display("FAIL abort_pulse: got %h want 000400", ab);     else passed++;
    checks++; if (act !== 21'h0003FF) $display("FAIL abort_restore: got %h want 0003ff", act);  else passed++;
    checks++; if (dn  !== 21'h000000) $display("FAIL abort_no_done: got %h want 000000", dn);   else passed++;
    checks++; if (rq  !== 21'h000000) $display("FAIL abort_no_req_ready: got %h want 000000", rq); else passed++;
    pll_locked = 1'b1;
    repeat (9) tick();
    checks++; if (req_ready !== 1'b0) $display("FAIL relock_early: got %b want 0", req_ready); else passed++;
    tick();
    checks++; if ({pll_ready, req_ready} !== 2'b11)
      $display("FAIL relock_ready: got %b want 11", {pll_ready, req_ready}); else passed++;
  endtask

  task automatic test_timeout();
    int   rise[3] = '{-1, -1, -1};
    int   nrise = 0, hi = 0;
    logic prev, steplo = 1'b0;
    pll_locked = 1'b0;
    prev = pll_rst;
    for (int k = 0; k < 216; k++) begin
      if (k > 0) tick();
      if (pll_rst === 1'b1) hi++;
      if (pll_rst === 1'b1 && prev === 1'b0 && nrise < 3) begin
        rise[nrise] = k;
        nrise++;
      end
      prev   = pll_rst;
      steplo = steplo | (phasestep === 1'b0);
    end
    // ready drops at 3, WAIT_LOCK 4..67, pulses at 68, 136, 204 (4 wide each)
    checks++; if (rise[0] != 68) $display("FAIL timeout_first: got %0d want 68", rise[0]); else passed++;
    checks++; if (rise[1] - rise[0] != 68)
      $display("FAIL timeout_period1: got %0d want 68", rise[1] - rise[0]); else passed++;
    checks++; if (rise[2] - rise[1] != 68)
      $display("FAIL timeout_period2: got %0d want 68", rise[2] - rise[1]); else passed++;
    checks++; if (hi != 12) $display("FAIL timeout_rst_width: got %0d want 12", hi); else passed++;
    checks++; if (steplo !== 1'b0) $display("FAIL timeout_step: got %b want 0", steplo); else passed++;
  endtask

  task automatic test_reset_mid_step();
    int   hi = 0;
    logic got = 1'b0, steplo = 1'b0, dn = 1'b0;
    pll_locked = 1'b1;
    for (int k = 0; k < 300 && !got; k++) begin
      tick();
      got = (req_ready === 1'b1);
    end
    checks++; if (got !== 1'b1) $display("FAIL midrst_relock: got %b want 1", got); else passed++;
    req_sel = 2'd1; req_dir = 1'b0; req_steps = 8'd4; req_valid = 1'b1;
    tick();
    req_valid = 1'b0;
    tick(); tick();
    checks++; if (phasestep !== 1'b0) $display("FAIL midrst_in_pulse: got %b want 0", phasestep); else passed++;
    #2;
    reset_n = 1'b0;
    #1;
    checks++; if ({pll_rst, phasesel, phasedir, phasestep} !== 5'b10011)
      $display("FAIL midrst_pins: got %b want 10011", {pll_rst, phasesel, phasedir, phasestep}); else passed++;
    checks++; if ({pll_ready, req_ready, done, aborted} !== 4'b0000)
      $display("FAIL midrst_status: got %b want 0000", {pll_ready, req_ready, done, aborted}); else passed++;
    tick(); tick();
    reset_n = 1'b1;
    if (pll_rst === 1'b1) hi++;
    for (int k = 1; k <= 12; k++) begin
      tick();
      if (pll_rst === 1'b1) hi++;
      steplo = steplo | (phasestep === 1'b0);
      dn     = dn | (done === 1'b1);
    end
    checks++; if (hi != 4) $display("FAIL midrst_rst_width: got %0d want 4", hi); else passed++;
    checks++; if ({steplo, dn} !== 2'b00)
      $display("FAIL midrst_quiet: got %b want 00", {steplo, dn}); else passed++;
  endtask

  initial begin
    test_reset();
    test_startup();
    test_step();
    test_zero_steps();
    test_abort();
    test_timeout();
    test_reset_mid_step();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
